mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that sits directly upstream of the parameterised Mux and drives its select input.
- Takes one request line per Mux channel, grants one channel at a time, and presents the registered select/grant with a valid/ready handshake to the consumer of the Mux output.
- Guarantees select is stable for as long as a transfer is pending, so the Mux output never changes mid-transfer.

---
 rtl/mux_rr_arbiter.sv | 112 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that drives a Mux select with a registered valid/ready handshake.
// Optional packet lock (hold the grant until last) is enabled by defining MUX_RR_ARB_PKT_LOCK_EN.
module mux_rr_arbiter #(
  parameter int unsigned SIZE     = 3,
  parameter int unsigned CHANNELS = 2**SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] req,
  input  logic                last,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [SIZE-1:0]     select,
  output logic [CHANNELS-1:0] grant
);

  if (CHANNELS != 2**SIZE) begin : g_bad_channels
    $error("mux_rr_arbiter: CHANNELS must equal 2**SIZE");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [SIZE-1:0]     ptr_q, ptr_d;
  logic [SIZE-1:0]     sel_q, sel_d;
  logic [CHANNELS-1:0] gnt_q, gnt_d;
  logic [SIZE-1:0]     base, win, idx;
  logic                found, any_req, lock_hold;

`ifdef MUX_RR_ARB_PKT_LOCK_EN
  assign lock_hold = ~last;
`else
  logic unused_last;
  assign unused_last = last;
  assign lock_hold   = 1'b0;
`endif

  assign any_req = |req;

  // In GRANT the scan starts just past the current winner, which is the
  // pointer value a handshake commits, so the current channel goes last.
  always_comb begin
    base  = (state_q == IDLE) ? ptr_q : sel_q + SIZE'(1);
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = base + SIZE'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = win;
          gnt_d   = CHANNELS'(1) << win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (out_ready && !lock_hold) begin
          ptr_d = base;
          if (any_req) begin
            sel_d = win;
            gnt_d = CHANNELS'(1) << win;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == GRANT);
    select    = sel_q;
    grant     = gnt_q;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && state_q == IDLE)
      assert (!$isunknown(req)) else $error("mux_rr_arbiter: req unknown while idle");
  end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a spec-level model checked every cycle plus literal expectations.
module tb_mux_rr_arbiter;
  localparam int SIZE = 3;
  localparam int CH   = 8;
`ifdef MUX_RR_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] req = '0;
  logic          last = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [SIZE-1:0] select;
  logic [CH-1:0] grant;

  int n_vec = 0;
  int n_bad = 0;

  int m_valid = 0;
  int m_sel   = 0;
  int m_ptr   = 0;

  logic [SIZE-1:0] ramp [CH];

  mux_rr_arbiter #(.SIZE(SIZE), .CHANNELS(CH)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .out_ready(out_ready),
    .out_valid(out_valid), .select(select), .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic int pick(input int start, input logic [CH-1:0] r);
    for (int k = 0; k < CH; k++)
      if (r[(start + k) % CH]) return (start + k) % CH;
    return 0;
  endfunction

  // Model: transfer on valid&&ready; winner scans from ptr; ptr = granted+1 after a transfer.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 0;
      m_sel   <= 0;
      m_ptr   <= 0;
    end else if (m_valid == 0) begin
      if (req != '0) begin
        m_sel   <= pick(m_ptr, req);
        m_valid <= 1;
      end
    end else if (out_ready && !(LOCK && !last)) begin
      m_ptr <= (m_sel + 1) % CH;
      if (req != '0) m_sel <= pick((m_sel + 1) % CH, req);
      else           m_valid <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_valid", 32'(out_valid), 32'(m_valid));
    chk("model_select", 32'(select), 32'(m_sel));
    chk("model_grant", 32'(grant), (m_valid != 0) ? (32'd1 << m_sel) : 32'd0);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; out_ready = 1'b0; last = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int exp_seq [5];

  initial begin
    for (int i = 0; i < CH; i++) ramp[i] = SIZE'(i);

    // 1: idle after reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 0);
      chk("t1_grant", 32'(grant), 0);
      chk("t1_select", 32'(select), 0);
    end

    // 2: all requesting, back-to-back rotation
    req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_valid", 32'(out_valid), 1);
      chk("t2_select", 32'(select), i % 8);
      chk("t2_grant", 32'(grant), 32'd1 << (i % 8));
      chk("t2_mux", 32'(ramp[select]), i % 8);
    end
    req = '0;
    @(negedge clk);
    chk("t2_idle", 32'(out_valid), 0);
    chk("t2_idle_grant", 32'(grant), 0);

    // 3: two requesters alternate, single requester re-granted
    do_reset();
    req = 8'b1000_0100; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_alt", 32'(select), (i % 2 == 0) ? 2 : 7);
    end
    req = 8'b0000_0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_single", 32'(select), 2);
      chk("t3_single_valid", 32'(out_valid), 1);
    end

    // 4: backpressure holds select/grant
    do_reset();
    req = 8'h08; out_ready = 1'b1;
    @(negedge clk);
    chk("t4_first", 32'(select), 3);
    out_ready = 1'b0; req = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_sel", 32'(select), 3);
      chk("t4_hold_gnt", 32'(grant), 32'h08);
      chk("t4_hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_next", 32'(select), 0);
    chk("t4_next_gnt", 32'(grant), 32'h01);

    // 5: async reset between edges
    do_reset();
    req = 8'h10; out_ready = 1'b0;
    @(negedge clk);
    chk("t5_grant4", 32'(select), 4);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_valid", 32'(out_valid), 0);
    chk("t5_async_grant", 32'(grant), 0);
    chk("t5_async_select", 32'(select), 0);
    @(negedge clk);
    reset = 1'b0; req = 8'b0010_0000;
    @(negedge clk);
    chk("t5_after", 32'(select), 5);
    chk("t5_after_valid", 32'(out_valid), 1);

    // 6: packet lock vs. per-beat re-arbitration
    if (LOCK) exp_seq = '{0, 0, 0, 0, 1};
    else      exp_seq = '{0, 1, 2, 3, 4};
    do_reset();
    req = 8'hFF; out_ready = 1'b1; last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_seq", 32'(select), 32'(exp_seq[i]));
      last = (i == 3);
    end
    req = '0; last = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
